// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file arbiter slice.
// The sequencer state enum is also exported on the debug port of regfile_arbiter.
package regfile_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_ADDR_W = 2;
    localparam int STAT_W     = 16;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the register-file arbiter.
// Requester k owns bit k of each per-requester vector and slice k of each packed field.
interface regfile_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ADDR_W  = DEF_ADDR_W
);

    // Handshake: a request transfers on the rising edge where req_valid[k] and
    // req_ready[k] are both high. req_ready is one-hot or zero and may depend on
    // req_valid in the same cycle. A requester holding req_valid while not granted
    // keeps we/addr/wdata/wmask stable. rsp_valid[k] pulses one cycle after a read
    // transfer; rsp_rdata is shared and holds its last value between pulses.
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]  req_wdata;
    logic [NUM_REQ*WIDTH-1:0]  req_wmask;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [WIDTH-1:0]          rsp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output req_wmask,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  req_wmask,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

endinterface

// File: rtl/regfile_storage.sv
// DEPTH x WIDTH array with a per-bit masked write port and a registered read port.
// The array itself has no reset; only the read register is cleared by rst_n.
module regfile_storage
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [WIDTH-1:0]  i_wmask,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= (r_mem[i_waddr] & ~i_wmask) | (i_wdata & i_wmask);
        end
    end

    // Read data only updates on a read, so it holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register file between NUM_REQ requesters; clears the
// array after every reset. Optional per-requester grant counters: REGFILE_ARB_STATS_EN.
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    regfile_arbiter_if.slave         bus,
    output logic                     init_done,
    output state_t                   dbg_state
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] grant_cnt
`endif
);

    localparam int                PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  LAST_REQ  = PTR_W'(NUM_REQ - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_init_ptr;
    logic [ADDR_W-1:0]  w_init_ptr_nxt;
    logic               r_init_done;
    logic               w_init_done_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   w_rr_ptr_nxt;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [NUM_REQ-1:0] w_rsp_valid_nxt;

    logic               w_found;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [PTR_W-1:0]   w_scan_idx;
    logic [NUM_REQ-1:0] w_gnt_onehot;

    logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
    logic [WIDTH-1:0]   w_wdata_arr [NUM_REQ];
    logic [WIDTH-1:0]   w_wmask_arr [NUM_REQ];
    logic               w_gnt_we;
    logic [ADDR_W-1:0]  w_gnt_addr;
    logic [WIDTH-1:0]   w_gnt_wdata;
    logic [WIDTH-1:0]   w_gnt_wmask;

    logic               w_mem_we;
    logic               w_mem_re;
    logic [ADDR_W-1:0]  w_mem_waddr;
    logic [WIDTH-1:0]   w_mem_wdata;
    logic [WIDTH-1:0]   w_mem_wmask;
    logic [WIDTH-1:0]   w_rdata;

    genvar k;
    generate
        for (k = 0; k < NUM_REQ; k++) begin : g_unpack
            assign w_addr_arr[k]  = bus.req_addr[k*ADDR_W +: ADDR_W];
            assign w_wdata_arr[k] = bus.req_wdata[k*WIDTH +: WIDTH];
            assign w_wmask_arr[k] = bus.req_wmask[k*WIDTH +: WIDTH];
        end
    endgenerate

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found    = 1'b0;
        w_gnt_idx  = '0;
        w_scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan_idx = PTR_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_found && bus.req_valid[w_scan_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan_idx;
            end
        end
    end

    assign w_gnt_we    = bus.req_we[w_gnt_idx];
    assign w_gnt_addr  = w_addr_arr[w_gnt_idx];
    assign w_gnt_wdata = w_wdata_arr[w_gnt_idx];
    assign w_gnt_wmask = w_wmask_arr[w_gnt_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_init_ptr  <= '0;
            r_init_done <= 1'b0;
            r_rr_ptr    <= '0;
            r_rsp_valid <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_ptr  <= w_init_ptr_nxt;
            r_init_done <= w_init_done_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_init_ptr_nxt  = r_init_ptr;
        w_init_done_nxt = r_init_done;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_rsp_valid_nxt = '0;
        w_gnt_onehot    = '0;
        w_mem_we        = 1'b0;
        w_mem_re        = 1'b0;
        w_mem_waddr     = w_gnt_addr;
        w_mem_wdata     = w_gnt_wdata;
        w_mem_wmask     = w_gnt_wmask;
        case (r_state)
            ST_INIT: begin
                // Sequencer owns the write port: one full-mask zero write per clock.
                w_mem_we       = 1'b1;
                w_mem_waddr    = r_init_ptr;
                w_mem_wdata    = '0;
                w_mem_wmask    = '1;
                w_init_ptr_nxt = r_init_ptr + 1'b1;
                if (r_init_ptr == LAST_ADDR) begin
                    w_state_nxt     = ST_RUN;
                    w_init_done_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_found) begin
                    w_gnt_onehot[w_gnt_idx] = 1'b1;
                    w_mem_we                = w_gnt_we;
                    w_mem_re                = !w_gnt_we;
                    if (!w_gnt_we) begin
                        w_rsp_valid_nxt[w_gnt_idx] = 1'b1;
                    end
                    w_rr_ptr_nxt = (w_gnt_idx == LAST_REQ) ? '0 : w_gnt_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    regfile_storage #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_storage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_wmask (w_mem_wmask),
        .i_re    (w_mem_re),
        .i_raddr (w_gnt_addr),
        .o_rdata (w_rdata)
    );

    assign bus.req_ready = w_gnt_onehot;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = w_rdata;
    assign init_done     = r_init_done;
    assign dbg_state     = r_state;

`ifdef REGFILE_ARB_STATS_EN
    logic [STAT_W-1:0] r_grant_cnt [NUM_REQ];

    // Saturating per-requester transfer counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_gnt_onehot[i] && bus.req_valid[i] && (r_grant_cnt[i] != '1)) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
                end
            end
        end
    end

    generate
        for (k = 0; k < NUM_REQ; k++) begin : g_stats
            assign grant_cnt[k*STAT_W +: STAT_W] = r_grant_cnt[k];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: directed vector table, reset/INIT sequences,
// and random traffic compared against a behavioural model (REGFILE_ARB_STATS_EN optional).
module tb_regfile_arbiter;
    import regfile_pkg::*;

    localparam int N  = 2;
    localparam int W  = 8;
    localparam int AW = 2;
    localparam int D  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ADDR_W(AW)) bus ();
    logic   init_done;
    state_t dbg_state;
`ifdef REGFILE_ARB_STATS_EN
    logic [N*STAT_W-1:0] grant_cnt;
`endif

    regfile_arbiter #(.NUM_REQ(N), .DEPTH(D), .WIDTH(W), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .init_done (init_done),
        .dbg_state (dbg_state)
`ifdef REGFILE_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: array contents, rotating priority, clear countdown, read scoreboard.
    logic [W-1:0] m_mem [D];
    int           m_rr;
    int           m_init_left;
    logic         m_init_done;
    logic [N-1:0] m_rsp_valid;
    logic [W-1:0] m_last;
    int           m_cnt [N];
    logic [W-1:0] exp_q [$];

    typedef struct {
        logic [N-1:0]    v;
        logic [N-1:0]    we;
        logic [N*AW-1:0] a;
        logic [N*W-1:0]  wd;
        logic [N*W-1:0]  wm;
        logic [N-1:0]    exp_ready;
        logic [N-1:0]    exp_rsp_valid;
        logic [W-1:0]    exp_rdata;
    } vec_t;
    vec_t tbl [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_rr        = 0;
        m_init_left = D;
        m_init_done = 1'b0;
        m_rsp_valid = '0;
        m_last      = '0;
        exp_q.delete();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // One clock: drive, sample at negedge against the model, advance the model, pass the edge.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] we, input logic [N*AW-1:0] a,
                         input logic [N*W-1:0] wd, input logic [N*W-1:0] wm, input string tag,
                         output logic [N-1:0] o_ready, output logic [N-1:0] o_rv,
                         output logic [W-1:0] o_rd);
        int           g;
        int           addr;
        logic [N-1:0] exp_ready;
        logic [W-1:0] mask;
        logic [W-1:0] data;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_wmask = wm;
        @(negedge clk);
        g         = m_init_done ? rr_pick(v, m_rr) : -1;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        if (m_rsp_valid != '0 && exp_q.size() > 0) m_last = exp_q.pop_front();
        o_ready = bus.req_ready;
        o_rv    = bus.rsp_valid;
        o_rd    = bus.rsp_rdata;
        check({tag, " model ready"}, 32'(bus.req_ready), 32'(exp_ready));
        check({tag, " model rsp_valid"}, 32'(bus.rsp_valid), 32'(m_rsp_valid));
        check({tag, " model rsp_rdata"}, 32'(bus.rsp_rdata), 32'(m_last));
        check({tag, " model init_done"}, 32'(init_done), 32'(m_init_done));
        check({tag, " model state"}, 32'(dbg_state), m_init_done ? 32'(ST_RUN) : 32'(ST_INIT));
`ifdef REGFILE_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            check({tag, " model grant_cnt"}, 32'(grant_cnt[i*STAT_W +: STAT_W]), 32'(m_cnt[i]));
        end
`endif
        m_rsp_valid = '0;
        if (!m_init_done) begin
            m_init_left--;
            if (m_init_left == 0) begin
                m_init_done = 1'b1;
                for (int i = 0; i < D; i++) m_mem[i] = '0;
            end
        end else if (g >= 0) begin
            addr = int'(a[g*AW +: AW]);
            mask = wm[g*W +: W];
            data = wd[g*W +: W];
            if (we[g]) begin
                m_mem[addr] = (m_mem[addr] & ~mask) | (data & mask);
            end else begin
                m_rsp_valid[g] = 1'b1;
                exp_q.push_back(m_mem[addr]);
            end
            m_rr = (g + 1) % N;
            if (m_cnt[g] < 65535) m_cnt[g]++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] rdy;
        logic [N-1:0] rv;
        logic [W-1:0] rd;

        tbl[0]  = '{2'b01, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b01, 2'b00, 8'h00};
        tbl[1]  = '{2'b01, 2'b00, 4'h1, 16'h0000, 16'h0000, 2'b01, 2'b01, 8'h00};
        tbl[2]  = '{2'b01, 2'b00, 4'h2, 16'h0000, 16'h0000, 2'b01, 2'b01, 8'h00};
        tbl[3]  = '{2'b01, 2'b00, 4'h3, 16'h0000, 16'h0000, 2'b01, 2'b01, 8'h00};
        tbl[4]  = '{2'b01, 2'b01, 4'h2, 16'h00A5, 16'h00FF, 2'b01, 2'b01, 8'h00};
        tbl[5]  = '{2'b01, 2'b00, 4'h2, 16'h0000, 16'h0000, 2'b01, 2'b00, 8'h00};
        tbl[6]  = '{2'b00, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b00, 2'b01, 8'hA5};
        tbl[7]  = '{2'b01, 2'b01, 4'h1, 16'h00F0, 16'h00FF, 2'b01, 2'b00, 8'hA5};
        tbl[8]  = '{2'b01, 2'b01, 4'h1, 16'h000F, 16'h003C, 2'b01, 2'b00, 8'hA5};
        tbl[9]  = '{2'b01, 2'b00, 4'h1, 16'h0000, 16'h0000, 2'b01, 2'b00, 8'hA5};
        tbl[10] = '{2'b00, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b00, 2'b01, 8'hCC};
        tbl[11] = '{2'b10, 2'b10, 4'h4, 16'hFF00, 16'h0000, 2'b10, 2'b00, 8'hCC};
        tbl[12] = '{2'b10, 2'b00, 4'h4, 16'h0000, 16'h0000, 2'b10, 2'b00, 8'hCC};
        tbl[13] = '{2'b00, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b00, 2'b10, 8'hCC};
        tbl[14] = '{2'b11, 2'b00, 4'h8, 16'h0000, 16'h0000, 2'b01, 2'b00, 8'hCC};
        tbl[15] = '{2'b11, 2'b00, 4'h8, 16'h0000, 16'h0000, 2'b10, 2'b01, 8'h00};
        tbl[16] = '{2'b11, 2'b00, 4'h8, 16'h0000, 16'h0000, 2'b01, 2'b10, 8'hA5};
        tbl[17] = '{2'b11, 2'b00, 4'h8, 16'h0000, 16'h0000, 2'b10, 2'b01, 8'h00};
        tbl[18] = '{2'b11, 2'b00, 4'h8, 16'h0000, 16'h0000, 2'b01, 2'b10, 8'hA5};
        tbl[19] = '{2'b11, 2'b00, 4'h8, 16'h0000, 16'h0000, 2'b10, 2'b01, 8'h00};
        tbl[20] = '{2'b10, 2'b00, 4'hC, 16'h0000, 16'h0000, 2'b10, 2'b10, 8'hA5};
        tbl[21] = '{2'b10, 2'b00, 4'hC, 16'h0000, 16'h0000, 2'b10, 2'b10, 8'h00};
        tbl[22] = '{2'b10, 2'b00, 4'h8, 16'h0000, 16'h0000, 2'b10, 2'b10, 8'h00};
        tbl[23] = '{2'b00, 2'b00, 4'h0, 16'h0000, 16'h0000, 2'b00, 2'b10, 8'hA5};

        for (int i = 0; i < D; i++) m_mem[i] = '0;
        model_reset();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;

        // Reset values while rst_n is held low.
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 32'(bus.req_ready), 32'(0));
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("reset rsp_rdata", 32'(bus.rsp_rdata), 32'(0));
        check("reset init_done", 32'(init_done), 32'(0));
        check("reset state", 32'(dbg_state), 32'(ST_INIT));
        rst_n = 1'b1;

        // Clear sequence with both requesters already asking.
        for (int c = 0; c < D; c++) begin
            cycle(2'b11, 2'b00, 4'h4, '0, '0, "init", rdy, rv, rd);
            check("init ready held low", 32'(rdy), 32'(0));
        end

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].wm, "vec", rdy, rv, rd);
            check($sformatf("vec%0d ready", i), 32'(rdy), 32'(tbl[i].exp_ready));
            check($sformatf("vec%0d rsp_valid", i), 32'(rv), 32'(tbl[i].exp_rsp_valid));
            check($sformatf("vec%0d rsp_rdata", i), 32'(rd), 32'(tbl[i].exp_rdata));
        end

        for (int c = 0; c < 400; c++) begin
            cycle(N'($urandom_range(0, 3)), N'($urandom_range(0, 3)), (N*AW)'($urandom()),
                  (N*W)'($urandom()), (N*W)'($urandom()), "rand", rdy, rv, rd);
        end

        // Reset right after a read grant: the pending response must be dropped.
        cycle(2'b01, 2'b00, 4'h2, '0, '0, "pre-reset read", rdy, rv, rd);
        check("pre-reset read granted", 32'(rdy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("mid reset ready", 32'(bus.req_ready), 32'(0));
        check("mid reset rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("mid reset rsp_rdata", 32'(bus.rsp_rdata), 32'(0));
        check("mid reset init_done", 32'(init_done), 32'(0));
        check("mid reset state", 32'(dbg_state), 32'(ST_INIT));
        @(negedge clk);
        check("mid reset rsp_valid negedge", 32'(bus.rsp_valid), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < D; c++) begin
            cycle(2'b11, 2'b00, 4'h4, '0, '0, "reinit", rdy, rv, rd);
            check("reinit ready held low", 32'(rdy), 32'(0));
        end
        for (int c = 0; c <= D; c++) begin
            cycle((c < D) ? 2'b01 : 2'b00, 2'b00, (N*AW)'(c % D), '0, '0, "cleared read", rdy, rv, rd);
            if (c > 0) check("cleared entry reads zero", 32'(rd), 32'(0));
        end

`ifdef REGFILE_ARB_STATS_EN
        for (int c = 0; c < 70000; c++) begin
            cycle(2'b01, 2'b00, 4'h0, '0, '0, "stats", rdy, rv, rd);
        end
        check("grant_cnt req0 saturated", 32'(grant_cnt[15:0]), 32'(16'hFFFF));
        check("grant_cnt req1 zero", 32'(grant_cnt[31:16]), 32'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares one 4-entry x 8-bit register file between NUM_REQ requesters.
- Requests are single-cycle reads or bit-masked writes, each with a valid/ready handshake.
- Requesters are granted round-robin.
- After every reset, a sequencer clears the array before any request is accepted.
- The block sits in front of the per-bit-written memory array used by the datapath and is the only agent that writes it.

Parameters:
- NUM_REQ, 2: number of requesters, 2..4.
- DEPTH, 4: number of entries.
- WIDTH, 8: bits per entry.
- ADDR_W, 2: address width; must equal clog2(DEPTH).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester k occupies slice k.
- req_wdata  in  NUM_REQ*WIDTH  packed write data.
- req_wmask  in  NUM_REQ*WIDTH  packed bit write-enables.
- rsp_valid  out  NUM_REQ  read response strobe, one-hot or zero.
- rsp_rdata  out  WIDTH  read data, shared by all requesters.
- init_done  out  1  high once the clear sequence has completed.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, state=INIT, init_ptr=0, rr_ptr=0.
  - Array contents are not reset asynchronously; the INIT state clears them.
- State INIT:
  - Each cycle writes 0 to entry init_ptr, then increments init_ptr.
  - After the write to entry DEPTH-1, moves to RUN and sets init_done=1.
  - Clearing DEPTH=4 entries takes 4 clocks after rst_n rises.
  - req_ready stays 0 throughout INIT.
- State RUN:
  - Stays in RUN until reset; there are no other states.
- Arbitration (combinational, RUN only):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit g gets req_ready[g]=1 in the same cycle.
  - req_ready may depend on req_valid.
  - A transfer occurs when valid and ready are both high.
- Pointer update:
  - On a transfer, rr_ptr <= (g+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds.
- Write transfer: at the clock edge, mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask).
  - wmask=0 leaves the entry unchanged but still consumes the grant.
- Read transfer:
  - Next cycle, rsp_valid[g]=1 and rsp_rdata=mem[addr]. Latency is 1.
  - rsp_valid is high for exactly one cycle.
  - rsp_rdata holds its last value otherwise.
- Ordering:
  - A read granted the cycle after a write to the same address returns the written data.
  - Only one access happens per cycle, so there are no same-cycle hazards.
- Address range: addresses are ADDR_W wide and always in range, since DEPTH=2^ADDR_W.
- Held requests: a requester that holds valid while not granted keeps its request stable. The arbiter does not check this.
- Reset mid-operation:
  - Asserting rst_n low at any point, including mid-INIT or with a read response pending, immediately forces the reset values.
  - Any pending rsp_valid is dropped.
  - INIT restarts from entry 0 after release.

Optional Feature:
- Macro: REGFILE_ARB_STATS_EN.
- When defined:
  - Adds output grant_cnt, width NUM_REQ*16.
  - Holds one 16-bit saturating counter per requester, incremented on each transfer to that requester.
  - Counters clear on reset and stick at 16'hFFFF.
- When undefined: the port and the counters are absent, and there is no other change.

Decomposition:
- Shared package regfile_pkg holds:
  - the state enum (ST_INIT, ST_RUN);
  - default DEPTH, WIDTH and ADDR_W constants;
  - the STAT_W=16 constant.
- Sub-module regfile_storage holds the DEPTH x WIDTH array with a masked write port and a registered read port; the arbiter drives it.
- Round-robin search stays inline.

Test Plan:
1. Release rst_n; hold req_valid=2'b11 -> req_ready=0 for 4 cycles, init_done rises on cycle 4, and reads of addresses 0..3 return 8'h00.
2. Requester 0 writes addr 2, wdata 8'hA5, wmask 8'hFF; next cycle requester 0 reads addr 2 -> rsp_valid=2'b01 one cycle later, rsp_rdata=8'hA5.
3. Entry 1 holds 8'hF0; write wdata 8'h0F, wmask 8'h3C; then read -> 8'hCC.
4. Both requesters hold valid for 6 cycles starting at rr_ptr=0 -> grants alternate 0,1,0,1,0,1; with only requester 1 valid, it is granted every cycle.
5. Pull rst_n low the cycle after a read grant -> rsp_valid never pulses, all outputs return to 0, and INIT replays its 4 cycles.
6. With REGFILE_ARB_STATS_EN defined: 70000 back-to-back grants to requester 0 -> grant_cnt[15:0]=16'hFFFF and requester 1's counter=0.
